// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: K full-adder cells reused N/K cycles per add.
// Optional subtract path enabled by defining SERIAL_ADD_SUB_EN (adds i_Sub).
//
// Ports:
//   i_CLK, i_RST        clock, sync active-high reset
//   i_valid / o_ready   operand handshake (i_A, i_B, i_Cin[, i_Sub])
//   i_flush             abort any operation in progress
//   o_valid / i_ready   result handshake (o_S, o_C, o_Ovf, o_Zero)
module serial_add_seq #(
  parameter int N = 32,
  parameter int K = 1
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  input  logic         i_Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         i_Sub,
`endif
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_S,
  output logic         o_C,
  output logic         o_Ovf,
  output logic         o_Zero
);

  localparam int STEPS = N / K;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (K < 1 || N < 2 || (N % K) != 0) begin : g_bad_cfg
    $error("serial_add_seq: need N>=2, K>=1, N%%K==0");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  s_q;
  logic          carry_q;
  logic          zacc;
  logic [CW-1:0] cnt;

  logic [K:0]    chunk;
  logic [K-1:0]  sum_chunk;
  logic          cout;
  logic          cin_msb;
  logic [N-1:0]  s_next;
  logic [N-1:0]  b_load;
  logic          c_load;

  assign o_ready = (state == IDLE) & ~i_RST;

  // K-cell ripple chain over the low chunk of the shift registers.
  always_comb begin
    chunk = {1'b0, a_q[K-1:0]}
          + {1'b0, b_q[K-1:0]}
          + {{K{1'b0}}, carry_q};
  end

  assign sum_chunk = chunk[K-1:0];
  assign cout      = chunk[K];
  // Carry into the top cell, recovered from its sum bit.
  assign cin_msb   = sum_chunk[K-1] ^ a_q[K-1] ^ b_q[K-1];

  // New sum bits enter at the MSB end; after N/K shifts they are aligned.
  assign s_next = (s_q >> K) | (N'(sum_chunk) << (N - K));

`ifdef SERIAL_ADD_SUB_EN
  assign b_load = i_Sub ? ~i_B : i_B;
  assign c_load = i_Sub ? 1'b1 : i_Cin;
`else
  assign b_load = i_B;
  assign c_load = i_Cin;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_S     <= '0;
      o_C     <= 1'b0;
      o_Ovf   <= 1'b0;
      o_Zero  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      zacc    <= 1'b0;
      cnt     <= '0;
    end else if (i_flush && state != IDLE) begin
      state   <= IDLE;
      o_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid && !i_flush) begin
            a_q     <= i_A;
            b_q     <= b_load;
            carry_q <= c_load;
            zacc    <= 1'b0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> K;
          b_q     <= b_q >> K;
          s_q     <= s_next;
          carry_q <= cout;
          zacc    <= zacc | (|sum_chunk);
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_S     <= s_next;
            o_C     <= cout;
            o_Ovf   <= cin_msb ^ cout;
            o_Zero  <= ~(zacc | (|sum_chunk));
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed-vector bench for serial_add_seq (N=32 with K=1 and K=4).
// Sub vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         valid4;
  logic         flush;
  logic         rdy_in;
  logic         rdy4;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         ready;
  logic         ov;
  logic         oc;
  logic         oovf;
  logic         oz;
  logic [N-1:0] s;
  logic         ready4;
  logic         ov4;
  logic         oc4;
  logic         ovf4;
  logic         oz4;
  logic [N-1:0] s4;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.N(N), .K(1)) dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_valid (valid),
    .o_ready (ready),
    .i_A     (a),
    .i_B     (b),
    .i_Cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .i_Sub   (sub),
`endif
    .i_flush (flush),
    .o_valid (ov),
    .i_ready (rdy_in),
    .o_S     (s),
    .o_C     (oc),
    .o_Ovf   (oovf),
    .o_Zero  (oz)
  );

  serial_add_seq #(.N(N), .K(4)) dut4 (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_valid (valid4),
    .o_ready (ready4),
    .i_A     (a),
    .i_B     (b),
    .i_Cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .i_Sub   (1'b0),
`endif
    .i_flush (flush),
    .o_valid (ov4),
    .i_ready (rdy4),
    .o_S     (s4),
    .o_C     (oc4),
    .o_Ovf   (ovf4),
    .o_Zero  (oz4)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input string       tag,
    input logic [31:0] ta,
    input logic [31:0] tb,
    input logic        tc,
    input logic [31:0] es,
    input logic        ec,
    input logic        eo,
    input logic        ez
  );
    int n;
    check({tag, "_rdy"}, ready, 1);
    a = ta;
    b = tb;
    cin = tc;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    a = ~ta;
    b = ~tb;
    cin = ~tc;
    n = 0;
    while (!ov && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 32);
    check({tag, "_s"}, s, es);
    check({tag, "_c"}, oc, ec);
    check({tag, "_ovf"}, oovf, eo);
    check({tag, "_z"}, oz, ez);
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    check({tag, "_vld0"}, ov, 0);
    check({tag, "_rdy1"}, ready, 1);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    valid = 1'b0;
    valid4 = 1'b0;
    flush = 1'b0;
    rdy_in = 1'b0;
    rdy4 = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    tick();
    tick();
    check("rst_rdy", ready, 0);
    check("rst_vld", ov, 0);
    check("rst_s", s, 0);
    check("rst_c", oc, 0);
    check("rst_ovf", oovf, 0);
    check("rst_z", oz, 0);
    rst = 1'b0;
    #1;
    check("rst_rdy1", ready, 1);

    run_op("t1", 32'h5, 32'h3, 0,
           32'h8, 0, 0, 0);
    run_op("t2a", 32'hFFFF_FFFF, 32'h1, 0,
           32'h0, 1, 0, 1);
    run_op("t2b", 32'h7FFF_FFFF, 32'h1, 0,
           32'h8000_0000, 0, 1, 0);
    run_op("cin", 32'h0, 32'h0, 1,
           32'h1, 0, 0, 0);

    // Backpressure in DONE with a pending request.
    a = 32'h10;
    b = 32'h20;
    valid = 1'b1;
    tick();
    a = 32'h999;
    n = 0;
    while (!ov && n < 100) begin
      tick();
      n++;
    end
    check("t3_lat", n, 32);
    for (int i = 0; i < 10; i++) begin
      check("t3_vld", ov, 1);
      check("t3_rdy", ready, 0);
      check("t3_s", s, 32'h30);
      tick();
    end
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    check("t3_rdy1", ready, 1);
    check("t3_vld0", ov, 0);
    check("t3_hold", s, 32'h30);
    valid = 1'b0;
    tick();
    check("t3_noacc", ready, 1);

    // Flush mid-RUN.
    a = 32'hAAAA;
    b = 32'h1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (10) tick();
    check("t4_run", ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_rdy", ready, 1);
    check("t4_vld", ov, 0);
    bad = 0;
    repeat (40) begin
      tick();
      if (ov) bad++;
    end
    check("t4_never", bad, 0);
    check("t4_keep", s, 32'h30);

    // Flush with valid in IDLE is not an accept.
    flush = 1'b1;
    valid = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    check("t4_idle", ready, 1);
    run_op("t4_next", 32'h1, 32'h1, 0,
           32'h2, 0, 0, 0);

    // Flush while holding a result in DONE.
    a = 32'h3;
    b = 32'h4;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n = 0;
    while (!ov && n < 100) begin
      tick();
      n++;
    end
    check("fd_lat", n, 32);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fd_vld", ov, 0);
    check("fd_rdy", ready, 1);

    // Reset mid-RUN.
    a = 32'hFFFF;
    b = 32'hFFFF;
    cin = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rr_rdy", ready, 0);
    check("rr_vld", ov, 0);
    check("rr_s", s, 0);
    rst = 1'b0;
    #1;
    check("rr_rdy1", ready, 1);
    run_op("rr_next", 32'h1, 32'h1, 0,
           32'h2, 0, 0, 0);

    // K=4 instance.
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    cin = 1'b1;
    check("t5_rdy", ready4, 1);
    valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    n = 0;
    while (!ov4 && n < 100) begin
      tick();
      n++;
    end
    check("t5_lat", n, 8);
    check("t5_s", s4, 32'h2345_678A);
    check("t5_c", oc4, 0);
    check("t5_ovf", ovf4, 0);
    check("t5_z", oz4, 0);
    rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    check("t5_vld0", ov4, 0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("t6a", 32'h5, 32'h7, 0,
           32'hFFFF_FFFE, 0, 0, 0);
    run_op("t6b", 32'h8000_0000, 32'h1, 0,
           32'h7FFF_FFFF, 1, 1, 0);
    run_op("t6c", 32'h9, 32'h9, 0,
           32'h0, 1, 0, 1);
    sub = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
